// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
// Imported by mux_arbiter and mux_arb_beat_cnt.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } mux_arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int   CNT_W = 4;

  // Resolve pending requests; prefer_b breaks a tie in favour of B.
  function automatic mux_arb_state_t pick_owner(input logic req_a, input logic req_b,
                                                input logic prefer_b);
    mux_arb_state_t nxt;
    if (req_a && req_b) nxt = prefer_b ? OWN_B : OWN_A;
    else if (req_a)     nxt = OWN_A;
    else if (req_b)     nxt = OWN_B;
    else                nxt = IDLE;
    return nxt;
  endfunction

endpackage

// File: rtl/mux_arb_beat_cnt.sv
// Beat counter for one grant tenure: clear on grant, count accepted beats,
// flag the beat that completes a MAX_BURST tenure.
module mux_arb_beat_cnt
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last_beat
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // A new grant outranks a beat landing on the same cycle.
  always_comb begin
    count_d = count_q;
    if (clr)      count_d = '0;
    else if (inc) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign last_beat = inc && (count_q == LAST_CNT);

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester burst arbiter steering one shared data path.
// MUX_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise A has fixed priority.
//   state | meaning
//   IDLE  | nobody owns the path, o_data follows o_sel
//   OWN_A | A owns the path, beats counted toward MAX_BURST
//   OWN_B | B owns the path, beats counted toward MAX_BURST
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_a,
  input  logic [DATA_W-1:0] i_data_a,
  output logic              o_gnt_a,
  input  logic              i_req_b,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_gnt_b,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_sel
);

  mux_arb_state_t state_d, state_q;
  logic gnt_a_d, gnt_a_q;
  logic gnt_b_d, gnt_b_q;
  logic sel_d, sel_q;
  logic beat, last_beat, release_own, arb_now, prefer_b;

`ifdef MUX_ARB_ROUND_ROBIN_EN
  logic last_d, last_q;
  assign prefer_b = (last_q == SEL_A);
`else
  assign prefer_b = 1'b0;
`endif

  assign o_valid = ((state_q == OWN_A) && i_req_a) || ((state_q == OWN_B) && i_req_b);
  assign beat    = o_valid && i_ready;

  mux_arb_beat_cnt #(.MAX_BURST(MAX_BURST)) u_beat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (arb_now),
    .inc       (beat),
    .last_beat (last_beat)
  );

  // Arbitration happens in IDLE and at every release, so hand-off costs no idle cycle.
  always_comb begin
    case (state_q)
      OWN_A:   release_own = !i_req_a || last_beat;
      OWN_B:   release_own = !i_req_b || last_beat;
      default: release_own = 1'b0;
    endcase
    arb_now = (state_q == IDLE) || release_own;
    state_d = state_q;
    sel_d   = sel_q;
    if (arb_now) begin
      state_d = pick_owner(i_req_a, i_req_b, prefer_b);
      if (state_d != IDLE) sel_d = (state_d == OWN_B) ? SEL_B : SEL_A;
    end
    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
  end

`ifdef MUX_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (arb_now && (state_d != IDLE)) last_d = sel_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      sel_q   <= SEL_A;
`ifdef MUX_ARB_ROUND_ROBIN_EN
      last_q  <= SEL_B;
`endif
    end else begin
      state_q <= state_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      sel_q   <= sel_d;
`ifdef MUX_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    case (state_q)
      OWN_A:   o_data = i_data_a;
      OWN_B:   o_data = i_data_b;
      default: o_data = (sel_q == SEL_B) ? i_data_b : i_data_a;
    endcase
  end

  assign o_gnt_a = gnt_a_q;
  assign o_gnt_b = gnt_b_q;
  assign o_sel   = sel_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter; expectations follow the build's tie-break mode.
// Rows: {req_a, req_b, ready} _ {gnt_a, gnt_b, valid, sel} _ beat count.
module tb_mux_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              i_req_a  = 1'b0;
  logic              i_req_b  = 1'b0;
  logic              i_ready  = 1'b0;
  logic [DATA_W-1:0] i_data_a = '0;
  logic [DATA_W-1:0] i_data_b = '0;
  logic [DATA_W-1:0] o_data;
  logic              o_gnt_a, o_gnt_b, o_valid, o_sel;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic              ga;
    logic              gb;
    logic              v;
    logic              sel;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] data;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  mux_arbiter #(.MAX_BURST(MAX_BURST), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req_a  (i_req_a),
    .i_data_a (i_data_a),
    .o_gnt_a  (o_gnt_a),
    .i_req_b  (i_req_b),
    .i_data_b (i_data_b),
    .o_gnt_b  (o_gnt_b),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .i_ready  (i_ready),
    .o_sel    (o_sel)
  );

  function automatic obs_t observe();
    obs_t o;
    o.ga = o_gnt_a; o.gb = o_gnt_b; o.v = o_valid; o.sel = o_sel;
    o.cnt = dut.u_beat_cnt.count_q;
    o.data = o_data;
    return o;
  endfunction

  // Apply one row of stimulus and queue the outputs that row should produce.
  task automatic drive_row(input logic [10:0] row);
    obs_t e;
    i_req_a  = row[10];
    i_req_b  = row[9];
    i_ready  = row[8];
    i_data_a = DATA_W'($urandom);
    i_data_b = DATA_W'($urandom);
    e.ga  = row[7];
    e.gb  = row[6];
    e.v   = row[5];
    e.sel = row[4];
    e.cnt = row[3:0];
    e.data = e.ga ? i_data_a : (e.gb ? i_data_b : (e.sel ? i_data_b : i_data_a));
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req_a = 1'b0; i_req_b = 1'b0; i_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n = 1'b0;
    i_req_a = 1'b1; i_req_b = 1'b1; i_ready = 1'b1;
    i_data_a = 8'h5A; i_data_b = 8'hC3;
    repeat (3) @(negedge clk);
    #1;
    e = '{ga: 1'b0, gb: 1'b0, v: 1'b0, sel: 1'b0, cnt: 4'd0, data: 8'h5A};
    exp_q.push_back(e);
    e = exp_q.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", o, e);
    end
    do_reset();
  endtask

  task automatic test_single_owner();
    logic [10:0] tbl[$];
    obs_t e, o;
    tbl = '{11'b101_0000_0000, 11'b101_1010_0000, 11'b101_1010_0001,
            11'b101_1010_0010, 11'b001_1000_0011, 11'b001_0000_0000};
    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk); drive_row(tbl[i]); #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single_owner row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_burst_contention();
    logic [10:0] tbl[$];
    obs_t e, o;
`ifdef MUX_ARB_ROUND_ROBIN_EN
    tbl = '{11'b111_0000_0000,
            11'b111_1010_0000, 11'b111_1010_0001, 11'b111_1010_0010, 11'b111_1010_0011,
            11'b111_0111_0000, 11'b111_0111_0001, 11'b111_0111_0010, 11'b111_0111_0011,
            11'b111_1010_0000, 11'b111_1010_0001, 11'b111_1010_0010, 11'b111_1010_0011,
            11'b001_0101_0000, 11'b001_0001_0000};
`else
    tbl = '{11'b111_0000_0000,
            11'b111_1010_0000, 11'b111_1010_0001, 11'b111_1010_0010, 11'b111_1010_0011,
            11'b111_1010_0000, 11'b111_1010_0001, 11'b111_1010_0010, 11'b111_1010_0011,
            11'b111_1010_0000, 11'b111_1010_0001, 11'b111_1010_0010, 11'b111_1010_0011,
            11'b001_1000_0000, 11'b001_0000_0000};
`endif
    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk); drive_row(tbl[i]); #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL burst_contention row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_ready_stall();
    logic [10:0] tbl[$];
    obs_t e, o;
    tbl = '{11'b011_0000_0000, 11'b011_0111_0000, 11'b011_0111_0001,
            11'b010_0111_0010, 11'b010_0111_0010, 11'b010_0111_0010,
            11'b010_0111_0010, 11'b010_0111_0010,
            11'b011_0111_0010, 11'b011_0111_0011,
            11'b001_0101_0000, 11'b001_0001_0000};
    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk); drive_row(tbl[i]); #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL ready_stall row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [10:0] pre[$];
    logic [10:0] post[$];
    obs_t e, o;
    pre  = '{11'b101_0000_0000, 11'b101_1010_0000, 11'b101_1010_0001, 11'b101_1010_0010};
    post = '{11'b111_0000_0000, 11'b111_1010_0000, 11'b011_1000_0001,
             11'b011_0111_0000, 11'b001_0101_0001, 11'b001_0001_0000};
    do_reset();
    foreach (pre[i]) begin
      @(negedge clk); drive_row(pre[i]); #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_mid_pre row %0d: got %h expected %h", i, o, e);
      end
    end
    // Reset lands while clk is low: the grant must drop with no clock edge.
    rst_n = 1'b0;
    i_req_a = 1'b0; i_req_b = 1'b0;
    #1;
    e = '{ga: 1'b0, gb: 1'b0, v: 1'b0, sel: 1'b0, cnt: 4'd0, data: i_data_a};
    exp_q.push_back(e);
    e = exp_q.pop_front(); o = observe(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_mid_async: got %h expected %h", o, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    foreach (post[i]) begin
      @(negedge clk); drive_row(post[i]); #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_mid_post row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_single_cycle_req();
    logic [10:0] tbl[$];
    obs_t e, o;
    tbl = '{11'b101_0000_0000, 11'b001_1000_0000, 11'b001_0000_0000, 11'b001_0000_0000};
    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk); drive_row(tbl[i]); #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single_cycle_req row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_tie_after_service();
    logic [10:0] tbl[$];
    obs_t e, o;
`ifdef MUX_ARB_ROUND_ROBIN_EN
    tbl = '{11'b101_0000_0000, 11'b001_1000_0000, 11'b111_0000_0000,
            11'b111_0111_0000, 11'b001_0101_0001, 11'b001_0001_0000};
`else
    tbl = '{11'b101_0000_0000, 11'b001_1000_0000, 11'b111_0000_0000,
            11'b111_1010_0000, 11'b001_1000_0001, 11'b001_0000_0000};
`endif
    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk); drive_row(tbl[i]); #1;
      e = exp_q.pop_front(); o = observe(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL tie_after_service row %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_owner();
    test_burst_contention();
    test_ready_stall();
    test_reset_mid_burst();
    test_single_cycle_req();
    test_tie_after_service();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
